bist_engine: RTL and testbench

- Pattern-generation and response-compaction engine that sits directly downstream of the JTAG TAP data register.
- Consumes the 16-bit command word that the TAP delivers on Update-DR, already synchronised into the clk_50MHz domain.
- During a self-test it drives the unit-under-logic (UUL) inputs from an LFSR and compacts the UUL outputs in a MISR.
- Publishes a 16-bit status word, which the TAP captures back on Capture-DR.

---
 rtl/bist_pkg.sv | 32 +++
 rtl/bist_misr.sv | 32 +++
 rtl/bist_engine.sv | 159 +++++++++++++++
 tb/tb_bist_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engine: opcodes, FSM states, LFSR/MISR
// polynomials, status word layout and single-step helpers.
package bist_pkg;

  localparam logic [3:0] OP_ABORT = 4'h0;
  localparam logic [3:0] OP_BIST  = 4'h3;
  localparam logic [3:0] OP_FUNC  = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } bist_state_t;

  localparam logic [5:0]  LFSR_TAPS = 6'h30;
  localparam logic [11:0] MISR_POLY = 12'h053;

  localparam int unsigned ST_BUSY_BIT = 15;
  localparam int unsigned ST_DONE_BIT = 14;
  localparam int unsigned ST_PASS_BIT = 13;
  localparam int unsigned ST_FUNC_BIT = 12;

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [11:0] misr_step(input logic [11:0] m, input logic [3:0] d);
    return {m[10:0], 1'b0} ^ (m[11] ? MISR_POLY : 12'h000) ^ {8'h00, d};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 12-bit multiple-input signature register with synchronous clear and enable.
// sig_next exposes the value the register takes on the coming edge.
module bist_misr
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  din,
  output logic [11:0] sig,
  output logic [11:0] sig_next
);

  always_comb begin
    sig_next = sig;
    if (clr) begin
      sig_next = '0;
    end else if (en) begin
      sig_next = misr_step(sig, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_engine.sv
// BIST engine behind the JTAG TAP data register: LFSR pattern generation
// into the UUL and MISR compaction of its response.
module bist_engine
  import bist_pkg::*;
#(
  parameter logic [5:0]  LFSR_SEED    = 6'h01,
  parameter int unsigned DEF_PATTERNS = 16,
  parameter int unsigned UUL_LAT      = 1,
  parameter logic [11:0] GOLDEN_SIG   = 12'h000
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [15:0] cmd,
  input  logic [5:0]  func_in,
  output logic [5:0]  uul_in,
  input  logic [3:0]  uul_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] status
);

  bist_state_t        state, state_d;
  logic               func_mode, func_mode_d;
  logic [5:0]         lfsr, lfsr_d;
  logic [11:0]        cnt, cnt_d;
  logic [1:0]         flush_cnt, flush_d;
  logic [UUL_LAT-1:0] vld, vld_d;
  logic               busy_d, done_d, pass_d;
  logic [5:0]         uul_in_d;
  logic [11:0]        misr_q, misr_d;
  logic               cmd_start, cmd_abort, cmd_func, misr_en;
  logic [11:0]        cnt_load;

  assign cmd_abort = cmd_valid && (cmd[15:12] == OP_ABORT);
  assign cmd_start = cmd_valid && (cmd[15:12] == OP_BIST) &&
                     ((state == ST_IDLE) || (state == ST_DONE));
  assign cmd_func  = cmd_valid && (cmd[15:12] == OP_FUNC) &&
                     ((state == ST_IDLE) || (state == ST_DONE));
  assign cnt_load  = (cmd[11:0] == 12'h000) ? 12'(DEF_PATTERNS - 1) : cmd[11:0] - 12'd1;

  // Each RUN cycle is tagged; the tag emerges UUL_LAT cycles later, exactly
  // when that pattern's response sits on uul_out.
  assign misr_en = vld[UUL_LAT-1] & ~cmd_abort;

  always_comb begin
    vld_d = '0;
    if (!cmd_abort) begin
      vld_d[0] = (state == ST_RUN);
      for (int unsigned i = 1; i < UUL_LAT; i++) begin
        vld_d[i] = vld[i-1];
      end
    end
  end

  bist_misr u_misr (
    .clk      (clk_50MHz),
    .rst_n    (rst_n),
    .clr      (cmd_start),
    .en       (misr_en),
    .din      (uul_out),
    .sig      (misr_q),
    .sig_next (misr_d)
  );

  always_comb begin
    state_d     = state;
    func_mode_d = func_mode;
    lfsr_d      = lfsr;
    cnt_d       = cnt;
    flush_d     = flush_cnt;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;

    case (state)
      ST_RUN: begin
        lfsr_d = lfsr_step(lfsr);
        if (cnt == 12'h000) begin
          state_d = ST_FLUSH;
          flush_d = 2'(UUL_LAT - 1);
        end else begin
          cnt_d = cnt - 12'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == 2'd0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_d == GOLDEN_SIG);
        end else begin
          flush_d = flush_cnt - 2'd1;
        end
      end
      default: ;
    endcase

    // Commands are decoded against the pre-transition state and override it.
    if (cmd_abort) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      func_mode_d = 1'b0;
    end else if (cmd_start) begin
      state_d     = ST_RUN;
      lfsr_d      = LFSR_SEED;
      cnt_d       = cnt_load;
      func_mode_d = 1'b0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end else if (cmd_func) begin
      state_d     = ST_IDLE;
      func_mode_d = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end

    uul_in_d = (state_d == ST_RUN) ? lfsr_d : (func_mode_d ? func_in : 6'h00);
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      func_mode <= 1'b0;
      lfsr      <= LFSR_SEED;
      cnt       <= '0;
      flush_cnt <= '0;
      vld       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      uul_in    <= '0;
    end else begin
      state     <= state_d;
      func_mode <= func_mode_d;
      lfsr      <= lfsr_d;
      cnt       <= cnt_d;
      flush_cnt <= flush_d;
      vld       <= vld_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      uul_in    <= uul_in_d;
    end
  end

  always_comb begin
    status              = {4'h0, misr_q};
    status[ST_BUSY_BIT] = busy;
    status[ST_DONE_BIT] = done;
    status[ST_PASS_BIT] = pass;
    status[ST_FUNC_BIT] = func_mode;
  end

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine: UUL stub is a one-register echo of uul_in[3:0],
// optionally corrupted while pattern 5 (6'h21) is applied.
module tb_bist_engine;

  function automatic logic [11:0] model_sig(input int n, input int bad);
    logic [5:0]  l;
    logic [11:0] m;
    logic [3:0]  r;
    l = 6'h01;
    m = 12'h000;
    for (int k = 0; k < n; k++) begin
      r = l[3:0];
      if (k == bad) r = r ^ 4'h1;
      m = {m[10:0], 1'b0} ^ (m[11] ? 12'h053 : 12'h000) ^ {8'h00, r};
      l = {l[4:0], l[5] ^ l[4]};
    end
    return m;
  endfunction

  localparam logic [11:0] SIG16 = model_sig(16, -1);

  logic        clk_50MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd       = 16'h0000;
  logic [5:0]  func_in   = 6'h00;
  logic [5:0]  uul_in;
  logic [3:0]  uul_out   = 4'h0;
  logic        busy, done, pass;
  logic [15:0] status;
  logic        inject    = 1'b0;

  int total  = 0;
  int passed = 0;
  logic [5:0] seq [32];
  int edges, busy_n, pat_n;
  logic [5:0] exp_seq [7];

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz)
    uul_out <= uul_in[3:0] ^ ((inject && uul_in == 6'h21) ? 4'h1 : 4'h0);

  bist_engine #(
    .LFSR_SEED    (6'h01),
    .DEF_PATTERNS (16),
    .UUL_LAT      (1),
    .GOLDEN_SIG   (SIG16)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .func_in   (func_in),
    .uul_in    (uul_in),
    .uul_out   (uul_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .status    (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [15:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk_50MHz);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge right after the edge that accepted START_BIST;
  // that edge counts as edge 1.
  task automatic run_wait(input int inj_edge, input logic [15:0] inj_cmd,
                          output int n_edges, output int n_busy, output int n_pat);
    n_edges = 1;
    n_busy  = 0;
    n_pat   = 0;
    while (done !== 1'b1 && n_edges < 200) begin
      if (busy === 1'b1) n_busy++;
      if (uul_in !== 6'h00) n_pat++;
      if (n_edges <= 32) seq[n_edges-1] = uul_in;
      cmd       = inj_cmd;
      cmd_valid = (n_edges == inj_edge);
      @(negedge clk_50MHz);
      n_edges++;
    end
    cmd_valid = 1'b0;
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    exp_seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};

    // Reset state
    repeat (2) @(negedge clk_50MHz);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_pass",   32'(pass),   32'd0);
    chk("rst_uul_in", 32'(uul_in), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_50MHz);

    // Default-length run with golden signature
    issue(16'h3000);
    run_wait(0, 16'h0000, edges, busy_n, pat_n);
    chk("def_done_edges", 32'(edges),  32'd18);
    chk("def_busy_cycles", 32'(busy_n), 32'd17);
    chk("def_patterns",   32'(pat_n),  32'd16);
    for (int i = 0; i < 7; i++)
      chk($sformatf("def_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    chk("def_pass",    32'(pass),   32'd1);
    chk("def_status",  32'(status), 32'({4'b0110, SIG16}));
    chk("def_uul_idle", 32'(uul_in), 32'd0);

    // Response corrupted during pattern 5
    inject = 1'b1;
    issue(16'h3000);
    run_wait(0, 16'h0000, edges, busy_n, pat_n);
    inject = 1'b0;
    chk("fault_pass", 32'(pass), 32'd0);
    chk("fault_sig",  32'(status[11:0]), 32'(model_sig(16, 5)));
    chk("fault_sig_differs", 32'(status[11:0] != SIG16), 32'd1);
    chk("fault_status_top", 32'(status[15:12]), 32'b0100);

    // Explicit count of 4
    issue(16'h3004);
    run_wait(0, 16'h0000, edges, busy_n, pat_n);
    chk("n4_done_edges", 32'(edges), 32'd6);
    chk("n4_patterns",   32'(pat_n), 32'd4);
    chk("n4_sig",  32'(status[11:0]), 32'(model_sig(4, -1)));
    chk("n4_pass", 32'(pass), 32'(model_sig(4, -1) == SIG16));
    chk("n4_uul_idle", 32'(uul_in), 32'd0);

    // Functional mode from DONE
    func_in = 6'h2A;
    issue(16'h4000);
    chk("func_status_top", 32'(status[15:12]), 32'b0001);
    chk("func_uul_in", 32'(uul_in), 32'h2A);
    func_in = 6'h15;
    #1;
    chk("func_latency_hold", 32'(uul_in), 32'h2A);
    @(negedge clk_50MHz);
    chk("func_track", 32'(uul_in), 32'h15);
    issue(16'h3000);
    chk("func_cleared", 32'(status[12]), 32'd0);
    chk("func_run_first", 32'(uul_in), 32'h01);
    run_wait(0, 16'h0000, edges, busy_n, pat_n);
    chk("func_run_sig", 32'(status[11:0]), 32'(SIG16));

    // START_BIST mid-RUN must not restart
    issue(16'h3000);
    run_wait(5, 16'h3000, edges, busy_n, pat_n);
    chk("restart_edges",   32'(edges), 32'd18);
    chk("restart_patterns", 32'(pat_n), 32'd16);
    chk("restart_sig", 32'(status[11:0]), 32'(SIG16));

    // ABORT mid-RUN
    issue(16'h3000);
    repeat (3) @(negedge clk_50MHz);
    issue(16'h0000);
    chk("abort_busy",  32'(busy),   32'd0);
    chk("abort_done",  32'(done),   32'd0);
    chk("abort_uul",   32'(uul_in), 32'd0);
    chk("abort_status_top", 32'(status[15:12]), 32'd0);
    issue(16'h4000);
    chk("abort_then_func", 32'(status[12]), 32'd1);
    issue(16'h0000);
    chk("abort_clears_func", 32'(status[12]), 32'd0);

    // Asynchronous reset during FLUSH
    issue(16'h3000);
    repeat (16) @(negedge clk_50MHz);
    chk("flush_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),   32'd0);
    chk("arst_done",   32'(done),   32'd0);
    chk("arst_pass",   32'(pass),   32'd0);
    chk("arst_uul",    32'(uul_in), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    @(negedge clk_50MHz);
    issue(16'h3000);
    run_wait(0, 16'h0000, edges, busy_n, pat_n);
    chk("post_rst_edges", 32'(edges), 32'd18);
    chk("post_rst_sig",  32'(status[11:0]), 32'(SIG16));
    chk("post_rst_pass", 32'(pass), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
